// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: decode-stage control FSM producing D2E control words.
// Tracks multi-word CALL/RET stack transfers, LDM immediates and post-branch
// flushes with internal state and counters. Outputs are combinational from
// (state, cnt, opcode, bubble). Build option CTRL_SEQ_INT_EN turns INT into a
// CALL-like multi-word push followed by an RTI-depth flush.

module ctrl_sequencer #(
  parameter int OPC_W     = 5,
  parameter int ALU_W     = 5,
  parameter int PC_WORDS  = 2,
  parameter int JMP_FLUSH = 1,
  parameter int RET_FLUSH = 2,
  parameter int RTI_FLUSH = 3,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             bubble,
  output logic [9:0]       ctrl,
  output logic [ALU_W-1:0] alu_sel,
  output logic             shift,
  output logic [1:0]       push_pop,
  output logic             is_push,
  output logic [CNT_W-1:0] word_idx,
  output logic             imm_phase,
  output logic             pc_hold,
  output logic             flushing
);

  // Opcode encodings shared with the decoder.
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_INC  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DEC  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_PUSH = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_POP  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_LDM  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_LDD  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_STD  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_SETC = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_CLRC = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(20);
  localparam logic [OPC_W-1:0] OP_JN   = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_JC   = OPC_W'(22);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(23);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(24);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(25);
  localparam logic [OPC_W-1:0] OP_RTI  = OPC_W'(26);
  localparam logic [OPC_W-1:0] OP_INT  = OPC_W'(27);
  // OP_RST (28) and 29..31 fall through to the NOP default.

  // ALU select encodings shared with the execute stage.
  localparam logic [ALU_W-1:0] ALU_NOP  = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_NOT  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_INC  = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_DEC  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_MOV  = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_SHL  = ALU_W'(9);
  localparam logic [ALU_W-1:0] ALU_SHR  = ALU_W'(10);
  localparam logic [ALU_W-1:0] ALU_LDD  = ALU_W'(11);
  localparam logic [ALU_W-1:0] ALU_STD  = ALU_W'(12);
  localparam logic [ALU_W-1:0] ALU_SETC = ALU_W'(13);
  localparam logic [ALU_W-1:0] ALU_CLRC = ALU_W'(14);
  localparam logic [ALU_W-1:0] ALU_JZ   = ALU_W'(15);
  localparam logic [ALU_W-1:0] ALU_JN   = ALU_W'(16);
  localparam logic [ALU_W-1:0] ALU_JC   = ALU_W'(17);
  localparam logic [ALU_W-1:0] ALU_JMP  = ALU_W'(18);

  // Control words, bit order {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}.
  localparam logic [9:0] CTRL_ALU    = 10'b0000001000;
  localparam logic [9:0] CTRL_BRANCH = 10'b0000000100;
  localparam logic [9:0] CTRL_MWRITE = 10'b0001000000;
  localparam logic [9:0] CTRL_MREAD  = 10'b0010000000;
  localparam logic [9:0] CTRL_LOAD   = 10'b0010101000;
  localparam logic [9:0] CTRL_IN     = 10'b1000001000;
  localparam logic [9:0] CTRL_OUT    = 10'b0100000000;
  localparam logic [9:0] CTRL_SETC   = 10'b0000000010;
  localparam logic [9:0] CTRL_CLRC   = 10'b0000000001;
  localparam logic [9:0] CTRL_IMM    = 10'b0000011000;
`ifndef CTRL_SEQ_INT_EN
  localparam logic [9:0] CTRL_INT    = 10'b0001000100;
`endif

  localparam logic [1:0] PP_PUSH = 2'b01;
  localparam logic [1:0] PP_POP  = 2'b11;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PC_WORDS - 1);
  localparam logic [CNT_W-1:0] JMP_CNT   = CNT_W'(JMP_FLUSH);
  localparam logic [CNT_W-1:0] RET_CNT   = CNT_W'(RET_FLUSH);
  localparam logic [CNT_W-1:0] RTI_CNT   = CNT_W'(RTI_FLUSH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDM_IMM,
    S_CALL_PUSH,
    S_RET_POP,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] call_flush_cnt;

`ifdef CTRL_SEQ_INT_EN
  // Remembers that the current push sequence came from INT, so its tail
  // flush uses the RTI depth instead of the JMP depth.
  logic int_q, int_d;
  assign call_flush_cnt = int_q ? RTI_CNT : JMP_CNT;
`else
  assign call_flush_cnt = JMP_CNT;
`endif

  // State and counter registers; reset lands in IDLE with a cleared counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
`ifdef CTRL_SEQ_INT_EN
      int_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CTRL_SEQ_INT_EN
      int_q   <= int_d;
`endif
    end
  end

  // Next-state and output decode: reset > FLUSH > bubble > state action.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
`ifdef CTRL_SEQ_INT_EN
    int_d     = int_q;
`endif
    ctrl      = '0;
    alu_sel   = ALU_NOP;
    shift     = 1'b0;
    push_pop  = 2'b00;
    is_push   = 1'b0;
    word_idx  = '0;
    imm_phase = 1'b0;
    pc_hold   = 1'b0;
    flushing  = 1'b0;

    if (rst) begin
      // Outputs stay at their NOP values while reset is asserted, even if
      // bubble is high; the registers are already being forced to IDLE.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_FLUSH) begin
      // Flush cycles run regardless of opcode and bubble; the PC is free.
      flushing = 1'b1;
      if (cnt_q <= CNT_ONE) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (bubble) begin
      // Inserted NOP: freeze sequencing, keep showing the pending word index.
      pc_hold = 1'b1;
      if (state_q == S_CALL_PUSH || state_q == S_RET_POP) begin
        word_idx = cnt_q;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          unique case (opcode)
            OP_NOT:  begin ctrl = CTRL_ALU; alu_sel = ALU_NOT; end
            OP_INC:  begin ctrl = CTRL_ALU; alu_sel = ALU_INC; end
            OP_DEC:  begin ctrl = CTRL_ALU; alu_sel = ALU_DEC; end
            OP_MOV:  begin ctrl = CTRL_ALU; alu_sel = ALU_MOV; end
            OP_ADD:  begin ctrl = CTRL_ALU; alu_sel = ALU_ADD; end
            OP_SUB:  begin ctrl = CTRL_ALU; alu_sel = ALU_SUB; end
            OP_AND:  begin ctrl = CTRL_ALU; alu_sel = ALU_AND; end
            OP_OR:   begin ctrl = CTRL_ALU; alu_sel = ALU_OR;  end
            OP_SHL:  begin ctrl = CTRL_ALU; alu_sel = ALU_SHL; shift = 1'b1; end
            OP_SHR:  begin ctrl = CTRL_ALU; alu_sel = ALU_SHR; shift = 1'b1; end
            OP_PUSH: begin
              ctrl     = CTRL_MWRITE;
              alu_sel  = ALU_MOV;
              push_pop = PP_PUSH;
              is_push  = 1'b1;
            end
            OP_POP:  begin ctrl = CTRL_LOAD; alu_sel = ALU_MOV; push_pop = PP_POP; end
            OP_LDD:  begin ctrl = CTRL_LOAD;   alu_sel = ALU_LDD; end
            OP_STD:  begin ctrl = CTRL_MWRITE; alu_sel = ALU_STD; end
            OP_IN:   begin ctrl = CTRL_IN;     alu_sel = ALU_MOV; end
            OP_OUT:  begin ctrl = CTRL_OUT;    alu_sel = ALU_MOV; end
            OP_SETC: begin ctrl = CTRL_SETC;   alu_sel = ALU_SETC; end
            OP_CLRC: begin ctrl = CTRL_CLRC;   alu_sel = ALU_CLRC; end
            // LDM itself is a NOP; the following cycle carries the immediate.
            OP_LDM:  state_d = S_LDM_IMM;
            OP_CALL: begin
              ctrl     = CTRL_MWRITE;
              alu_sel  = ALU_STD;
              push_pop = PP_PUSH;
`ifdef CTRL_SEQ_INT_EN
              int_d    = 1'b0;
`endif
              if (PC_WORDS == 1) begin
                state_d = (JMP_CNT == '0) ? S_IDLE : S_FLUSH;
                cnt_d   = JMP_CNT;
              end else begin
                state_d = S_CALL_PUSH;
                cnt_d   = CNT_ONE;
              end
            end
            OP_RET: begin
              ctrl     = CTRL_MREAD;
              alu_sel  = ALU_MOV;
              push_pop = PP_POP;
              if (PC_WORDS == 1) begin
                state_d = (RET_CNT == '0) ? S_IDLE : S_FLUSH;
                cnt_d   = RET_CNT;
              end else begin
                state_d = S_RET_POP;
                cnt_d   = CNT_ONE;
              end
            end
            OP_JZ, OP_JN, OP_JC, OP_JMP: begin
              unique case (opcode)
                OP_JZ:   alu_sel = ALU_JZ;
                OP_JN:   alu_sel = ALU_JN;
                OP_JC:   alu_sel = ALU_JC;
                default: alu_sel = ALU_JMP;
              endcase
              state_d = (JMP_CNT == '0) ? S_IDLE : S_FLUSH;
              cnt_d   = JMP_CNT;
            end
            OP_RTI: begin
              ctrl    = CTRL_BRANCH;
              state_d = (RTI_CNT == '0) ? S_IDLE : S_FLUSH;
              cnt_d   = RTI_CNT;
            end
`ifdef CTRL_SEQ_INT_EN
            // INT saves the PC exactly like CALL, then flushes like RTI.
            OP_INT: begin
              ctrl     = CTRL_MWRITE;
              alu_sel  = ALU_STD;
              push_pop = PP_PUSH;
              int_d    = 1'b1;
              if (PC_WORDS == 1) begin
                state_d = (RTI_CNT == '0) ? S_IDLE : S_FLUSH;
                cnt_d   = RTI_CNT;
              end else begin
                state_d = S_CALL_PUSH;
                cnt_d   = CNT_ONE;
              end
            end
`else
            OP_INT:  ctrl = CTRL_INT;
`endif
            default: ; // NOP, RST and unused encodings decode to NOP
          endcase
        end

        S_LDM_IMM: begin
          ctrl      = CTRL_IMM;
          alu_sel   = ALU_MOV;
          imm_phase = 1'b1;
          pc_hold   = 1'b1;
          state_d   = S_IDLE;
        end

        S_CALL_PUSH: begin
          ctrl     = CTRL_MWRITE;
          push_pop = PP_PUSH;
          word_idx = cnt_q;
          pc_hold  = 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = (call_flush_cnt == '0) ? S_IDLE : S_FLUSH;
            cnt_d   = call_flush_cnt;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_RET_POP: begin
          ctrl     = CTRL_MREAD;
          alu_sel  = ALU_MOV;
          push_pop = PP_POP;
          word_idx = cnt_q;
          pc_hold  = 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = (RET_CNT == '0) ? S_IDLE : S_FLUSH;
            cnt_d   = RET_CNT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: three instances (PC_WORDS=2 default,
// PC_WORDS=3, PC_WORDS=1 with zero JMP flush). Each step pushes the expected
// output word on drive and pops/compares it at the following falling edge.

module tb_ctrl_sequencer;

  localparam logic [4:0] OP_NOP = 0, OP_NOT = 1, OP_INC = 2, OP_DEC = 3, OP_MOV = 4,
    OP_ADD = 5, OP_SUB = 6, OP_AND = 7, OP_OR = 8, OP_SHL = 9, OP_SHR = 10,
    OP_PUSH = 11, OP_POP = 12, OP_LDM = 13, OP_LDD = 14, OP_STD = 15, OP_IN = 16,
    OP_OUT = 17, OP_SETC = 18, OP_CLRC = 19, OP_JZ = 20, OP_JN = 21, OP_JC = 22,
    OP_JMP = 23, OP_CALL = 24, OP_RET = 25, OP_RTI = 26, OP_INT = 27, OP_RST = 28;

  localparam logic [4:0] A_NOP = 0, A_NOT = 1, A_INC = 2, A_DEC = 3, A_MOV = 4,
    A_ADD = 5, A_SUB = 6, A_AND = 7, A_OR = 8, A_SHL = 9, A_SHR = 10, A_LDD = 11,
    A_STD = 12, A_SETC = 13, A_CLRC = 14, A_JZ = 15, A_JN = 16, A_JC = 17, A_JMP = 18;

  typedef struct packed {
    logic [9:0] ctrl;
    logic [4:0] alu;
    logic       shift;
    logic [1:0] pp;
    logic       isp;
    logic [1:0] widx;
    logic       imm;
    logic       hold;
    logic       fl;
  } obs_t;

  typedef struct {
    int         d;
    logic [4:0] o;
    logic       b;
    obs_t       e;
    string      nm;
  } step_t;

  typedef struct {
    int    d;
    obs_t  e;
    string nm;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] opc    [0:2];
  logic       bub    [0:2];
  logic [9:0] ctrl_w [0:2];
  logic [4:0] alu_w  [0:2];
  logic       sh_w   [0:2];
  logic [1:0] pp_w   [0:2];
  logic       isp_w  [0:2];
  logic [1:0] wi_w   [0:2];
  logic       imm_w  [0:2];
  logic       ph_w   [0:2];
  logic       fl_w   [0:2];
  obs_t       obs    [0:2];

  sb_t exp_q[$];
  int  n_run  = 0;
  int  n_fail = 0;

  ctrl_sequencer u_a (
    .clk(clk), .rst(rst), .opcode(opc[0]), .bubble(bub[0]),
    .ctrl(ctrl_w[0]), .alu_sel(alu_w[0]), .shift(sh_w[0]), .push_pop(pp_w[0]),
    .is_push(isp_w[0]), .word_idx(wi_w[0]), .imm_phase(imm_w[0]),
    .pc_hold(ph_w[0]), .flushing(fl_w[0]));

  ctrl_sequencer #(.PC_WORDS(3)) u_b (
    .clk(clk), .rst(rst), .opcode(opc[1]), .bubble(bub[1]),
    .ctrl(ctrl_w[1]), .alu_sel(alu_w[1]), .shift(sh_w[1]), .push_pop(pp_w[1]),
    .is_push(isp_w[1]), .word_idx(wi_w[1]), .imm_phase(imm_w[1]),
    .pc_hold(ph_w[1]), .flushing(fl_w[1]));

  ctrl_sequencer #(.PC_WORDS(1), .JMP_FLUSH(0)) u_c (
    .clk(clk), .rst(rst), .opcode(opc[2]), .bubble(bub[2]),
    .ctrl(ctrl_w[2]), .alu_sel(alu_w[2]), .shift(sh_w[2]), .push_pop(pp_w[2]),
    .is_push(isp_w[2]), .word_idx(wi_w[2]), .imm_phase(imm_w[2]),
    .pc_hold(ph_w[2]), .flushing(fl_w[2]));

  assign obs[0] = {ctrl_w[0], alu_w[0], sh_w[0], pp_w[0], isp_w[0], wi_w[0], imm_w[0], ph_w[0], fl_w[0]};
  assign obs[1] = {ctrl_w[1], alu_w[1], sh_w[1], pp_w[1], isp_w[1], wi_w[1], imm_w[1], ph_w[1], fl_w[1]};
  assign obs[2] = {ctrl_w[2], alu_w[2], sh_w[2], pp_w[2], isp_w[2], wi_w[2], imm_w[2], ph_w[2], fl_w[2]};

  function automatic obs_t mk(input logic [9:0] c, input logic [4:0] a, input logic sh,
                              input logic [1:0] pp, input logic ip, input logic [1:0] w,
                              input logic im, input logic h, input logic f);
    obs_t r;
    r.ctrl = c; r.alu = a; r.shift = sh; r.pp = pp; r.isp = ip;
    r.widx = w; r.imm = im; r.hold = h; r.fl = f;
    return r;
  endfunction

  function automatic step_t stp(input int d, input logic [4:0] o, input logic b,
                                input obs_t e, input string nm);
    step_t s;
    s.d = d; s.o = o; s.b = b; s.e = e; s.nm = nm;
    return s;
  endfunction

  // Frequently used expected words.
  function automatic obs_t nopv();             return mk(10'b0, A_NOP, 0, 2'b00, 0, 2'd0, 0, 0, 0); endfunction
  function automatic obs_t flv();              return mk(10'b0, A_NOP, 0, 2'b00, 0, 2'd0, 0, 0, 1); endfunction
  function automatic obs_t holdv(input logic [1:0] w); return mk(10'b0, A_NOP, 0, 2'b00, 0, w, 0, 1, 0); endfunction
  function automatic obs_t aluv(input logic [4:0] a); return mk(10'b0000001000, a, 0, 2'b00, 0, 2'd0, 0, 0, 0); endfunction
  function automatic obs_t callv();            return mk(10'b0001000000, A_STD, 0, 2'b01, 0, 2'd0, 0, 0, 0); endfunction
  function automatic obs_t pushv(input logic [1:0] w); return mk(10'b0001000000, A_NOP, 0, 2'b01, 0, w, 0, 1, 0); endfunction
  function automatic obs_t retv();             return mk(10'b0010000000, A_MOV, 0, 2'b11, 0, 2'd0, 0, 0, 0); endfunction
  function automatic obs_t popv(input logic [1:0] w);  return mk(10'b0010000000, A_MOV, 0, 2'b11, 0, w, 0, 1, 0); endfunction
  function automatic obs_t immv();             return mk(10'b0000011000, A_MOV, 0, 2'b00, 0, 2'd0, 1, 1, 0); endfunction

  task automatic test_reset();
    sb_t got;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin opc[k] = OP_NOP; bub[k] = 1'b0; end
    // Busy inputs during reset must not leak through.
    opc[0] = OP_ADD; bub[0] = 1'b1; opc[1] = OP_CALL;
    exp_q.push_back('{d: 0, e: nopv(), nm: "reset_a"});
    exp_q.push_back('{d: 1, e: nopv(), nm: "reset_b"});
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; opc[0] = OP_NOP; bub[0] = 1'b0; opc[1] = OP_NOP;
  endtask

  task automatic test_decode();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(0, OP_NOT,  0, aluv(A_NOT), "dec_not"));
    st.push_back(stp(0, OP_INC,  0, aluv(A_INC), "dec_inc"));
    st.push_back(stp(0, OP_DEC,  0, aluv(A_DEC), "dec_dec"));
    st.push_back(stp(0, OP_MOV,  0, aluv(A_MOV), "dec_mov"));
    st.push_back(stp(0, OP_ADD,  0, aluv(A_ADD), "dec_add"));
    st.push_back(stp(0, OP_SUB,  0, aluv(A_SUB), "dec_sub"));
    st.push_back(stp(0, OP_AND,  0, aluv(A_AND), "dec_and"));
    st.push_back(stp(0, OP_OR,   0, aluv(A_OR),  "dec_or"));
    st.push_back(stp(0, OP_SHL,  0, mk(10'b0000001000, A_SHL, 1, 2'b00, 0, 0, 0, 0, 0), "dec_shl"));
    st.push_back(stp(0, OP_SHR,  0, mk(10'b0000001000, A_SHR, 1, 2'b00, 0, 0, 0, 0, 0), "dec_shr"));
    st.push_back(stp(0, OP_PUSH, 0, mk(10'b0001000000, A_MOV, 0, 2'b01, 1, 0, 0, 0, 0), "dec_push"));
    st.push_back(stp(0, OP_POP,  0, mk(10'b0010101000, A_MOV, 0, 2'b11, 0, 0, 0, 0, 0), "dec_pop"));
    st.push_back(stp(0, OP_LDD,  0, mk(10'b0010101000, A_LDD, 0, 2'b00, 0, 0, 0, 0, 0), "dec_ldd"));
    st.push_back(stp(0, OP_STD,  0, mk(10'b0001000000, A_STD, 0, 2'b00, 0, 0, 0, 0, 0), "dec_std"));
    st.push_back(stp(0, OP_IN,   0, mk(10'b1000001000, A_MOV, 0, 2'b00, 0, 0, 0, 0, 0), "dec_in"));
    st.push_back(stp(0, OP_OUT,  0, mk(10'b0100000000, A_MOV, 0, 2'b00, 0, 0, 0, 0, 0), "dec_out"));
    st.push_back(stp(0, OP_SETC, 0, mk(10'b0000000010, A_SETC, 0, 2'b00, 0, 0, 0, 0, 0), "dec_setc"));
    st.push_back(stp(0, OP_CLRC, 0, mk(10'b0000000001, A_CLRC, 0, 2'b00, 0, 0, 0, 0, 0), "dec_clrc"));
    st.push_back(stp(0, OP_INT,  0, mk(10'b0001000100, A_NOP, 0, 2'b00, 0, 0, 0, 0, 0), "dec_int"));
    st.push_back(stp(0, OP_NOP,  0, nopv(), "dec_nop"));
    st.push_back(stp(0, OP_RST,  0, nopv(), "dec_rst"));
    st.push_back(stp(0, 5'd31,   0, nopv(), "dec_unknown"));
    st.push_back(stp(0, OP_SUB,  0, aluv(A_SUB), "dec_after_unknown"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[0] = OP_NOP;
  endtask

  task automatic test_ldm();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(0, OP_LDM, 0, nopv(),      "ldm_cycle0"));
    st.push_back(stp(0, OP_ADD, 0, immv(),      "ldm_imm"));
    st.push_back(stp(0, OP_ADD, 0, aluv(A_ADD), "ldm_then_add"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[0] = OP_NOP;
  endtask

  task automatic test_call_words();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(1, OP_CALL, 0, callv(),     "call3_w0"));
    st.push_back(stp(1, OP_ADD,  0, pushv(2'd1), "call3_w1"));
    st.push_back(stp(1, OP_ADD,  0, pushv(2'd2), "call3_w2"));
    st.push_back(stp(1, OP_ADD,  0, flv(),       "call3_flush"));
    st.push_back(stp(1, OP_ADD,  0, aluv(A_ADD), "call3_idle"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[1] = OP_NOP;
  endtask

  task automatic test_ret_pop();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(0, OP_RET, 0, retv(),      "ret_w0"));
    st.push_back(stp(0, OP_RET, 0, popv(2'd1),  "ret_w1"));
    st.push_back(stp(0, OP_RET, 0, flv(),       "ret_flush1"));
    st.push_back(stp(0, OP_RET, 0, flv(),       "ret_flush2"));
    st.push_back(stp(0, OP_AND, 0, aluv(A_AND), "ret_idle"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[0] = OP_NOP;
  endtask

  task automatic test_bubble_call();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(0, OP_CALL, 0, callv(),     "bcall_w0"));
    st.push_back(stp(0, OP_NOP,  1, holdv(2'd1), "bcall_bubble1"));
    st.push_back(stp(0, OP_NOP,  1, holdv(2'd1), "bcall_bubble2"));
    st.push_back(stp(0, OP_NOP,  0, pushv(2'd1), "bcall_w1"));
    st.push_back(stp(0, OP_NOP,  0, flv(),       "bcall_flush"));
    st.push_back(stp(0, OP_OR,   0, aluv(A_OR),  "bcall_idle"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[0] = OP_NOP; bub[0] = 1'b0;
  endtask

  task automatic test_jmp_flush();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(0, OP_JMP, 0, mk(10'b0, A_JMP, 0, 2'b00, 0, 0, 0, 0, 0), "jmp"));
    st.push_back(stp(0, OP_ADD, 1, flv(),       "jmp_flush_bubble"));
    st.push_back(stp(0, OP_INC, 0, aluv(A_INC), "jmp_idle"));
    st.push_back(stp(0, OP_JN,  0, mk(10'b0, A_JN, 0, 2'b00, 0, 0, 0, 0, 0), "jn"));
    st.push_back(stp(0, OP_JN,  0, flv(),       "jn_flush"));
    st.push_back(stp(0, OP_RTI, 0, mk(10'b0000000100, A_NOP, 0, 2'b00, 0, 0, 0, 0, 0), "rti"));
    st.push_back(stp(0, OP_RTI, 0, flv(),       "rti_flush1"));
    st.push_back(stp(0, OP_RTI, 1, flv(),       "rti_flush2"));
    st.push_back(stp(0, OP_RTI, 0, flv(),       "rti_flush3"));
    st.push_back(stp(0, OP_DEC, 0, aluv(A_DEC), "rti_idle"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[0] = OP_NOP; bub[0] = 1'b0;
  endtask

  task automatic test_zero_flush();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(2, OP_CALL, 0, callv(),     "w1_call"));
    st.push_back(stp(2, OP_ADD,  0, aluv(A_ADD), "w1_call_idle"));
    st.push_back(stp(2, OP_JZ,   0, mk(10'b0, A_JZ, 0, 2'b00, 0, 0, 0, 0, 0), "zero_jz"));
    st.push_back(stp(2, OP_SUB,  0, aluv(A_SUB), "zero_jz_idle"));
    st.push_back(stp(2, OP_RET,  0, retv(),      "w1_ret"));
    st.push_back(stp(2, OP_RET,  0, flv(),       "w1_ret_flush1"));
    st.push_back(stp(2, OP_RET,  0, flv(),       "w1_ret_flush2"));
    st.push_back(stp(2, OP_NOT,  0, aluv(A_NOT), "w1_ret_idle"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[2] = OP_NOP;
  endtask

  task automatic test_reset_midcall();
    sb_t got;
    opc[0] = OP_CALL;
    exp_q.push_back('{d: 0, e: callv(), nm: "rmid_call"});
    @(negedge clk);
    got = exp_q.pop_front();
    n_run++;
    if (obs[got.d] !== got.e) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
    end
    @(posedge clk); #1;
    // Now in CALL_PUSH with cnt=1: assert reset asynchronously.
    opc[0] = OP_NOP; rst = 1'b1;
    exp_q.push_back('{d: 0, e: nopv(), nm: "rmid_reset"});
    @(negedge clk);
    got = exp_q.pop_front();
    n_run++;
    if (obs[got.d] !== got.e) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
    end
    @(posedge clk); #1;
    rst = 1'b0; opc[0] = OP_ADD;
    exp_q.push_back('{d: 0, e: aluv(A_ADD), nm: "rmid_add"});
    @(negedge clk);
    got = exp_q.pop_front();
    n_run++;
    if (obs[got.d] !== got.e) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
    end
    @(posedge clk); #1;
    opc[0] = OP_NOP;
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    sb_t   got;
    st.push_back(stp(0, OP_ADD, 1, holdv(2'd0), "b2b_add_bubble"));
    st.push_back(stp(0, OP_ADD, 0, aluv(A_ADD), "b2b_add"));
    st.push_back(stp(0, OP_LDM, 1, holdv(2'd0), "b2b_ldm_bubble"));
    st.push_back(stp(0, OP_LDM, 0, nopv(),      "b2b_ldm"));
    st.push_back(stp(0, OP_JC,  1, holdv(2'd0), "b2b_imm_bubble"));
    st.push_back(stp(0, OP_JC,  0, immv(),      "b2b_imm"));
    st.push_back(stp(0, OP_JC,  0, mk(10'b0, A_JC, 0, 2'b00, 0, 0, 0, 0, 0), "b2b_jc"));
    st.push_back(stp(0, OP_PUSH,0, flv(),       "b2b_jc_flush"));
    st.push_back(stp(0, OP_PUSH,0, mk(10'b0001000000, A_MOV, 0, 2'b01, 1, 0, 0, 0, 0), "b2b_push"));
    st.push_back(stp(0, OP_SHR, 0, mk(10'b0000001000, A_SHR, 1, 2'b00, 0, 0, 0, 0, 0), "b2b_shr"));
    foreach (st[i]) begin
      opc[st[i].d] = st[i].o; bub[st[i].d] = st[i].b;
      exp_q.push_back('{d: st[i].d, e: st[i].e, nm: st[i].nm});
      @(negedge clk);
      got = exp_q.pop_front();
      n_run++;
      if (obs[got.d] !== got.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", got.nm, obs[got.d], got.e);
      end
      @(posedge clk); #1;
    end
    opc[0] = OP_NOP; bub[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_ldm();
    test_call_words();
    test_ret_pop();
    test_bubble_call();
    test_jmp_flush();
    test_zero_flush();
    test_reset_midcall();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
